// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the MEM stage.
// State encoding, writeback control bit positions and alignment mask.
package pipe_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Loadable saturating counter used to bound data-memory access latency.
// tc is high while the count sits at the terminal value.
module dmem_timeout_ctr #(
    parameter int CNT_W = 8,
    parameter logic [CNT_W-1:0] TERM = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != TERM)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == TERM);

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access controller: req/ack bus, pipeline stall,
// bubble insertion into MEM/WB, misalignment and timeout error flags.
module mem_access_stage
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  WB,
    input  logic [4:0]  Rd,
    input  logic [31:0] ALURes,
    input  logic [31:0] WriteData,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        Stall,
    output logic [1:0]  WBOut,
    output logic [4:0]  RdOut,
    output logic [31:0] MemOut,
    output logic [31:0] ALUOut,
    output logic        MisalignErr,
    output logic        BusErr
);

    mem_state_t state, state_nx;

    logic mem_op;
    logic misalign;
    logic issue;
    logic tc;
    logic done;

    assign mem_op   = MemRead | MemWrite;
    assign misalign = |(ALURes[1:0] & WORD_ALIGN_MASK);
    assign issue    = (state == IDLE) && mem_op && !misalign;
    assign done     = (state == ACCESS) && (dmem_ack || tc);

    assign RdOut  = Rd;
    assign ALUOut = ALURes;

    dmem_timeout_ctr #(
        .CNT_W (CNT_W),
        .TERM  (CNT_W'(TIMEOUT - 1))
    ) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .clr      (done),
        .load     (issue),
        .load_val ('0),
        .en       (state == ACCESS),
        .tc       (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (issue) state_nx = ACCESS;
            ACCESS:  if (done)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        Stall       = 1'b0;
        WBOut       = 2'b00;
        MemOut      = 32'h0;
        MisalignErr = 1'b0;
        BusErr      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!mem_op) begin
                    WBOut = WB;
                end else if (misalign) begin
                    MisalignErr = 1'b1;
                end else begin
                    Stall = 1'b1;
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    WBOut  = WB;
                    MemOut = dmem_we ? 32'h0 : dmem_rdata;
                end else if (tc) begin
                    BusErr = 1'b1;
                end else begin
                    Stall = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Bus signals hold their issued values for the whole access.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_wdata <= 32'h0;
        end else if (issue) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWrite;
            dmem_addr  <= ALURes;
            dmem_wdata <= WriteData;
        end else if (done) begin
            dmem_req   <= 1'b0;
        end
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage data-memory access controller between the EX/MEM register and the MEM/WB register of the 5-stage pipeline.
- Drives a variable-latency req/ack data-memory bus and asserts Stall to freeze PC, IF/ID, ID/EX and EX/MEM while an access is outstanding.
- Presents WB, Rd, MemOut and ALU result to MEM/WB, inserting bubbles (WBOut = 0) until the access completes.

Parameters:
- TIMEOUT, 16, maximum cycles in ACCESS without dmem_ack before the access is aborted (range 2..255).
- CNT_W, 8, width of the timeout counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- MemRead  in  1  load request from EX/MEM
- MemWrite  in  1  store request from EX/MEM
- WB  in  2  writeback control from EX/MEM ([1]=RegWrite, [0]=MemtoReg)
- Rd  in  5  destination register from EX/MEM
- ALURes  in  32  ALU result; also the word address for loads/stores
- WriteData  in  32  store data from EX/MEM
- dmem_req  out  1  bus request, registered
- dmem_we  out  1  bus write enable, registered
- dmem_addr  out  32  bus word address, registered
- dmem_wdata  out  32  bus store data, registered
- dmem_rdata  in  32  bus read data; valid only when dmem_ack=1
- dmem_ack  in  1  one-cycle completion pulse from memory
- Stall  out  1  freeze upstream stages (combinational)
- WBOut  out  2  to MEM/WB WB; 0 = bubble
- RdOut  out  5  to MEM/WB Rd (pass-through of Rd)
- MemOut  out  32  to MEM/WB MemOut
- ALUOut  out  32  to MEM/WB ALURes (pass-through of ALURes)
- MisalignErr  out  1  one-cycle flag: access with ALURes[1:0] != 0
- BusErr  out  1  one-cycle flag: access aborted by timeout

Behaviour:
- Reset (synchronous): state=IDLE, cnt=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0. Stall, WBOut, MisalignErr and BusErr are 0 in the cycle after reset.
- mem_op = MemRead | MemWrite. MemRead and MemWrite both set is treated as a write.
- IDLE, no mem_op:
  - WBOut=WB, MemOut=0, Stall=0.
  - Zero added latency; MEM/WB captures at the next edge.
- IDLE, mem_op, ALURes[1:0] != 0:
  - No request issued; MisalignErr=1, WBOut=0, Stall=0.
  - The instruction is dropped and the state stays IDLE.
- IDLE, mem_op, aligned:
  - Stall=1, WBOut=0.
  - At the edge: dmem_req<=1, dmem_we<=MemWrite, dmem_addr<=ALURes, dmem_wdata<=WriteData, cnt<=0, state<=ACCESS.
- ACCESS:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable until completion or abort.
  - cnt increments each cycle.
  - EX/MEM is frozen by Stall, so WB, Rd and ALURes remain those of the current instruction.
- ACCESS, dmem_ack=1:
  - Stall=0, WBOut=WB, MemOut=dmem_rdata (for stores MemOut=0).
  - At the edge: dmem_req<=0, state<=IDLE.
  - Minimum access = 2 cycles (issue + ack).
- ACCESS, dmem_ack=0, cnt < TIMEOUT-1: Stall=1, WBOut=0.
- ACCESS, dmem_ack=0, cnt == TIMEOUT-1:
  - BusErr=1, Stall=0, WBOut=0; the instruction is dropped.
  - At the edge: dmem_req<=0, state<=IDLE.
- dmem_ack while in IDLE is ignored.
- Back-to-back memory ops: the next op issues from IDLE in the cycle after completion; there is no dead cycle beyond that.
- Reset during ACCESS: at the edge dmem_req=0 and state=IDLE; any later ack is ignored.
- RdOut=Rd and ALUOut=ALURes at all times. MEM/WB writes back only when WBOut[1]=1, so bubbles are safe.
- The counter saturates and never wraps while in ACCESS.

Decomposition:
- Shared package pipe_pkg: state encoding (IDLE=1'b0, ACCESS=1'b1), WB bit indices (WB_REGWRITE=1, WB_MEMTOREG=0), WORD_ALIGN_MASK=2'b11.
- Sub-module dmem_timeout_ctr: loadable saturating counter with clear, enable and a terminal-count output. The FSM stays in the top module.

Test Plan:
- Non-mem op (MemRead=0, MemWrite=0, WB=2'b10, Rd=5, ALURes=0x1234) -> same cycle WBOut=2'b10, RdOut=5, ALUOut=0x1234, Stall=0, dmem_req never rises.
- Load at ALURes=0x40, memory acks after 3 cycles with rdata=0xDEADBEEF -> Stall=1 and WBOut=0 for 3 cycles; ack cycle gives WBOut=2'b11, MemOut=0xDEADBEEF, Stall=0; dmem_req low the next cycle.
- Store at 0x80 with WriteData=0xCAFEF00D, ack on the first ACCESS cycle -> dmem_we=1, dmem_addr=0x80, dmem_wdata=0xCAFEF00D held until ack; total Stall=1 cycle.
- Load at 0x42 (misaligned) -> MisalignErr=1 for one cycle, WBOut=0, Stall=0, no dmem_req.
- TIMEOUT=4, load with no ack -> Stall high 4 cycles; BusErr=1 and WBOut=0 in the 4th ACCESS cycle; state returns to IDLE; a late ack is ignored.
- rst asserted 2 cycles into ACCESS, then back-to-back loads 0x10 and 0x14 with 1-cycle ack -> after reset req=0 and Stall=0; the two loads complete on consecutive accesses with correct MemOut.
